// File: rtl/aes_pkg.sv
// Shared AES affine-stage constants, mode encoding and rotate helper.
package aes_pkg;

  localparam logic [7:0] AES_AFF_FWD_C = 8'h63;
  localparam logic [7:0] AES_AFF_INV_C = 8'h05;

  localparam logic AFF_MODE_FWD = 1'b0;
  localparam logic AFF_MODE_INV = 1'b1;

  // 8-bit rotate-left by a constant amount in 1..7
  function automatic logic [7:0] aes_rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] dbl;
    dbl = {b, b} << n;
    return dbl[15:8];
  endfunction

endpackage

// File: rtl/aes_affine_lane.sv
// Combinational per-byte AES affine transform; the inverse path exists only
// when AES_AFFINE_INV_EN is defined, otherwise every byte is forward-transformed.
module aes_affine_lane
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       mode,
  output logic [7:0] out_byte
);

  logic [7:0] fwd_byte;

  assign fwd_byte = in_byte
                  ^ aes_rotl8(in_byte, 1)
                  ^ aes_rotl8(in_byte, 2)
                  ^ aes_rotl8(in_byte, 3)
                  ^ aes_rotl8(in_byte, 4)
                  ^ AES_AFF_FWD_C;

`ifdef AES_AFFINE_INV_EN
  logic [7:0] inv_byte;

  assign inv_byte = aes_rotl8(in_byte, 1)
                  ^ aes_rotl8(in_byte, 3)
                  ^ aes_rotl8(in_byte, 6)
                  ^ AES_AFF_INV_C;

  assign out_byte = (mode == AFF_MODE_INV) ? inv_byte : fwd_byte;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign out_byte    = fwd_byte;
`endif

endmodule

// File: rtl/aes_affine_out_pipe.sv
// Two-stage valid/ready pipeline applying the AES affine (or, with
// AES_AFFINE_INV_EN defined, per-beat selectable inverse affine) to LANES bytes.
module aes_affine_out_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic               s1_v;
  logic               s2_v;
  logic               s1_adv;
  logic               s2_adv;
  logic [8*LANES-1:0] s1_data;
  logic [8*LANES-1:0] s1_result;
  logic               s1_mode;

  // in_ready looks through both stages to out_ready; there is no skid buffer
  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      out_data <= '0;
      beat_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= in_valid;
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_data <= s1_result;
        end
      end
      if (s2_v && out_ready) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data <= in_data;
    end
  end

`ifdef AES_AFFINE_INV_EN
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_mode <= in_mode;
    end
  end
`else
  logic unused_in_mode;

  assign unused_in_mode = in_mode;
  assign s1_mode        = AFF_MODE_FWD;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_affine_lane u_lane (
      .in_byte  (s1_data[8*k +: 8]),
      .mode     (s1_mode),
      .out_byte (s1_result[8*k +: 8])
    );
  end

endmodule
